add_accum: RTL and testbench
============================

ADD_ACCUM -- requirements
Module: add_accum

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal >= 2).
REQ-002 Parameter SPLIT, default WIDTH/2, number of low bits added in stage 1 (legal 1..WIDTH-1).
REQ-003 Parameter SAT, default 0, 1 enables unsigned saturation of results.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  upstream presents op/a/b/cin.
REQ-007 in_ready  out  1  block accepts a transaction this cycle.
REQ-008 op  in  2  00 ADD a+b+cin, 01 SUB a-b, 10 ACC acc+a, 11 LOAD acc:=a.
REQ-009 a, b  in  WIDTH  unsigned operands; b ignored for ACC/LOAD.
REQ-010 cin  in  1  carry-in, used by ADD only.
REQ-011 out_valid  out  1  result beat present.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 sum  out  WIDTH  result.
REQ-014 cout  out  1  carry out of bit WIDTH-1 (SUB: 1 = no borrow).
REQ-015 ovf  out  1  two's-complement signed overflow of the operation.
REQ-016 acc  out  WIDTH  current accumulator register.

Function
REQ-017 Transfer occurs on a rising edge where valid and ready are both 1, on either port.
REQ-018 Two-stage pipeline: stage 1 computes bits [SPLIT-1:0] and registers the inter-stage carry; stage 2 computes bits [WIDTH-1:SPLIT], cout and ovf.
REQ-019 Latency: an input accepted at edge k produces out_valid=1 after edge k+2 when out_ready was not stalling.
REQ-020 SUB computed as a + ~b + 1; ACC computed as acc + a with carry-in 0; LOAD yields sum=a, cout=0, ovf=0.
REQ-021 ovf = (sign(x) == sign(y)) && (sign(sum) != sign(x)), where x and y are the effective addends (y = ~b for SUB).
REQ-022 SAT=1: ADD/ACC with cout=1 give sum all-ones; SUB with cout=0 gives sum 0; cout and ovf still report the unsaturated result.
REQ-023 acc updates to the (possibly saturated) sum when an ACC or LOAD op leaves stage 2 into the output register; ADD/SUB never modify acc.
REQ-024 Hazard rule: in_ready=0 while any ACC or LOAD op occupies stage 1 or stage 2, independent of the incoming op.
REQ-025 Backpressure: when out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold stable; stages advance only into empty or emptying slots.
REQ-026 Otherwise in_ready=1 unless both stages and the output register are full and out_ready=0, giving full throughput of one beat per cycle.
REQ-027 Accepted beats are never dropped or duplicated; order is preserved.
REQ-028 out_valid, in_ready and all outputs are driven purely from registers, except in_ready, which may depend combinationally on out_ready.

Reset
REQ-029 rst_n low asynchronously clears all valid flags, sum, cout, ovf and acc to 0.
REQ-030 While rst_n is low, in_ready=0.
REQ-031 in_ready=1 on the first edge after rst_n deasserts.
REQ-032 Reset mid-operation discards all in-flight beats with no output produced.

Verification (WIDTH=8, SPLIT=4)
REQ-033 SAT=0, ADD a=200 b=100 cin=0, out_ready=1 -> two edges later sum=44 cout=1 ovf=0.
REQ-034 SAT=1, same stimulus -> sum=255 cout=1; then SUB a=5 b=7 -> sum=0 cout=0.
REQ-035 SAT=0, SUB a=5 b=7 -> sum=254 cout=0 ovf=0; ADD a=127 b=1 -> sum=128 ovf=1.
REQ-036 Sequence LOAD 10, ACC 20, ACC 250 -> acc 10, 30, 24 in turn; in_ready=0 in each cycle an ACC/LOAD is in flight; the final ACC reports cout=1.
REQ-037 Back-to-back ADDs 1+1 .. 6+1 with out_ready low for 3 cycles mid-stream -> results 2..7 in order, none lost, with outputs stable while stalled.
REQ-038 rst_n pulsed low with two beats in flight -> out_valid=0 and acc=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/add_accum_if.sv
// Handshake bundle between an upstream producer, add_accum and a downstream consumer.
interface add_accum_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, acc
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, acc
  );
endinterface

// File: rtl/add_accum.sv
// Split-carry two-stage adder/subtractor with accumulator and optional unsigned saturation.
// Input accepted at edge k appears at the output after edge k+2; each slot advances only into an empty or emptying slot.
module add_accum #(
  parameter int WIDTH = 8,
  parameter int SPLIT = WIDTH / 2,
  parameter bit SAT   = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  add_accum_if.slave bus
);
  localparam int HW = WIDTH - SPLIT;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic             r_live;
  logic             r_s1_vld;
  logic [1:0]       r_s1_op;
  logic [HW-1:0]    r_s1_xh;
  logic [HW-1:0]    r_s1_yh;
  logic [SPLIT-1:0] r_s1_lo;
  logic             r_s1_c;
  logic             r_s2_vld;
  logic [1:0]       r_s2_op;
  logic [WIDTH-1:0] r_s2_sum;
  logic             r_s2_cout;
  logic             r_s2_ovf;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_c;
  logic [SPLIT:0]   w_lo;
  logic [HW:0]      w_hi;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_out_en;
  logic             w_s2_en;
  logic             w_s1_en;
  logic             w_hazard;
  logic             w_take;

  // Effective addends: x + y + c covers all four ops.
  always_comb begin
    w_x = bus.a;
    w_y = bus.b;
    w_c = bus.cin;
    case (bus.op)
      OP_SUB:  begin w_y = ~bus.b; w_c = 1'b1; end
      OP_ACC:  begin w_x = r_acc;  w_y = bus.a; w_c = 1'b0; end
      OP_LOAD: begin w_y = '0;     w_c = 1'b0; end
      default: ;
    endcase
  end

  assign w_lo  = {1'b0, w_x[SPLIT-1:0]} + {1'b0, w_y[SPLIT-1:0]} + {{SPLIT{1'b0}}, w_c};
  assign w_hi  = {1'b0, r_s1_xh} + {1'b0, r_s1_yh} + {{HW{1'b0}}, r_s1_c};
  assign w_ovf = (r_s1_xh[HW-1] == r_s1_yh[HW-1]) && (w_hi[HW-1] != r_s1_xh[HW-1]);

  always_comb begin
    w_sum = {w_hi[HW-1:0], r_s1_lo};
    if (SAT) begin
      if ((r_s1_op == OP_ADD || r_s1_op == OP_ACC) && w_hi[HW])
        w_sum = '1;
      else if (r_s1_op == OP_SUB && !w_hi[HW])
        w_sum = '0;
    end
  end

  assign w_out_en = !r_out_vld || bus.out_ready;
  assign w_s2_en  = !r_s2_vld || w_out_en;
  assign w_s1_en  = !r_s1_vld || w_s2_en;
  // ACC and LOAD both have op[1] set; block entry until acc has been written back.
  assign w_hazard = (r_s1_vld && r_s1_op[1]) || (r_s2_vld && r_s2_op[1]);
  assign w_take   = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = r_live && !w_hazard && w_s1_en;
  assign bus.out_valid = r_out_vld;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.acc       = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_op   <= '0;
      r_s1_xh   <= '0;
      r_s1_yh   <= '0;
      r_s1_lo   <= '0;
      r_s1_c    <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_op   <= '0;
      r_s2_sum  <= '0;
      r_s2_cout <= 1'b0;
      r_s2_ovf  <= 1'b0;
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_acc     <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_s1_en) begin
        r_s1_vld <= w_take;
        if (w_take) begin
          r_s1_op <= bus.op;
          r_s1_xh <= w_x[WIDTH-1:SPLIT];
          r_s1_yh <= w_y[WIDTH-1:SPLIT];
          r_s1_lo <= w_lo[SPLIT-1:0];
          r_s1_c  <= w_lo[SPLIT];
        end
      end
      if (w_s2_en) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_op   <= r_s1_op;
          r_s2_sum  <= w_sum;
          r_s2_cout <= w_hi[HW];
          r_s2_ovf  <= w_ovf;
        end
      end
      if (w_out_en) begin
        r_out_vld <= r_s2_vld;
        if (r_s2_vld) begin
          r_sum  <= r_s2_sum;
          r_cout <= r_s2_cout;
          r_ovf  <= r_s2_ovf;
          if (r_s2_op[1])
            r_acc <= r_s2_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_add_accum.sv
// Bench for add_accum: a SAT=0 and a SAT=1 instance share one stimulus stream and are scored against an arithmetic model.
module tb_add_accum;
  localparam int W = 8;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         d_vld;
  logic [1:0]   d_op;
  logic [W-1:0] d_a;
  logic [W-1:0] d_b;
  logic         d_cin;
  logic         d_ordy;

  add_accum_if #(.WIDTH(W)) bus0 ();
  add_accum_if #(.WIDTH(W)) bus1 ();

  assign bus0.in_valid = d_vld;  assign bus1.in_valid = d_vld;
  assign bus0.op = d_op;         assign bus1.op = d_op;
  assign bus0.a = d_a;           assign bus1.a = d_a;
  assign bus0.b = d_b;           assign bus1.b = d_b;
  assign bus0.cin = d_cin;       assign bus1.cin = d_cin;
  assign bus0.out_ready = d_ordy; assign bus1.out_ready = d_ordy;

  add_accum #(.WIDTH(W), .SPLIT(4), .SAT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  add_accum #(.WIDTH(W), .SPLIT(4), .SAT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Plain integer arithmetic: unsigned sum for result/carry, signed sum for overflow.
  function automatic res_t model(input logic [1:0] op, input int a, input int b,
                                 input int cin, input int acc, input bit sat);
    res_t r;
    int full, sres, sa, sb, sacc;
    sa   = (a   >= 128) ? a   - 256 : a;
    sb   = (b   >= 128) ? b   - 256 : b;
    sacc = (acc >= 128) ? acc - 256 : acc;
    case (op)
      2'd0:    begin full = a + b + cin;       sres = sa + sb + cin; end
      2'd1:    begin full = a + (255 - b) + 1; sres = sa - sb;       end
      2'd2:    begin full = acc + a;           sres = sacc + sa;     end
      default: begin full = a;                 sres = sa;            end
    endcase
    r.op   = op;
    r.sum  = full[7:0];
    r.cout = (full >= 256);
    r.ovf  = (sres > 127) || (sres < -128);
    if (sat) begin
      if ((op == 2'd0 || op == 2'd2) && r.cout) r.sum = 8'hFF;
      if (op == 2'd1 && !r.cout)                r.sum = 8'h00;
    end
    return r;
  endfunction

  // Scoreboard state, one entry per DUT instance.
  res_t         q0[$];
  res_t         q1[$];
  int           m_acc[2];
  int           n_out[2];
  logic         live;
  logic         p_hold[2];
  logic [W-1:0] p_sum[2];
  logic         p_cout[2];
  logic         p_ovf[2];
  logic         s_vld[2], s_rdy[2], s_cout[2], s_ovf[2];
  logic [W-1:0] s_sum[2], s_acc[2];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;

  always @(negedge clk) begin
    s_vld[0] = bus0.out_valid; s_rdy[0] = bus0.in_ready; s_sum[0] = bus0.sum;
    s_cout[0] = bus0.cout;     s_ovf[0] = bus0.ovf;      s_acc[0] = bus0.acc;
    s_vld[1] = bus1.out_valid; s_rdy[1] = bus1.in_ready; s_sum[1] = bus1.sum;
    s_cout[1] = bus1.cout;     s_ovf[1] = bus1.ovf;      s_acc[1] = bus1.acc;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      for (int k = 0; k < 2; k++) begin m_acc[k] = 0; p_hold[k] = 1'b0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        res_t q[$];
        res_t e;
        int   first, inflight;
        bit   haz, exp_rdy;
        q = (k == 0) ? q0 : q1;
        first    = s_vld[k] ? 1 : 0;
        inflight = q.size() - first;
        haz = 1'b0;
        for (int i = first; i < q.size(); i++) if (q[i].op[1]) haz = 1'b1;
        exp_rdy = live && !haz && !(inflight >= 2 && s_vld[k] && !d_ordy);
        chk($sformatf("d%0d in_ready", k), s_rdy[k], exp_rdy);
        if (p_hold[k]) begin
          chk($sformatf("d%0d hold out_valid", k), s_vld[k], 1);
          chk($sformatf("d%0d hold sum", k), s_sum[k], p_sum[k]);
          chk($sformatf("d%0d hold cout/ovf", k), {s_cout[k], s_ovf[k]}, {p_cout[k], p_ovf[k]});
        end
        if (s_vld[k] && q.size() == 0)
          chk($sformatf("d%0d unexpected out_valid", k), 1, 0);
        if (s_vld[k] && d_ordy && q.size() > 0) begin
          e = q.pop_front();
          n_out[k]++;
          chk($sformatf("d%0d sum", k), s_sum[k], e.sum);
          chk($sformatf("d%0d cout", k), s_cout[k], e.cout);
          chk($sformatf("d%0d ovf", k), s_ovf[k], e.ovf);
          if (e.op[1]) chk($sformatf("d%0d acc", k), s_acc[k], e.sum);
        end
        p_hold[k] = s_vld[k] && !d_ordy;
        p_sum[k]  = s_sum[k];
        p_cout[k] = s_cout[k];
        p_ovf[k]  = s_ovf[k];
        if (d_vld && s_rdy[k]) begin
          e = model(d_op, d_a, d_b, d_cin, m_acc[k], k == 1);
          q.push_back(e);
          if (d_op[1]) m_acc[k] = e.sum;
        end
        if (k == 0) q0 = q; else q1 = q;
      end
    end
  end

  task automatic send(input logic [1:0] op, input int a, input int b, input int cin);
    int t = 0;
    d_vld = 1'b1; d_op = op; d_a = a[7:0]; d_b = b[7:0]; d_cin = cin[0];
    @(negedge clk);
    while (!bus0.in_ready && t < 50) begin t++; @(negedge clk); end
    chk("accept", bus0.in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    d_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    int   n_before;
    rst_n = 1'b0; d_vld = 1'b0; d_op = 2'd0; d_a = '0; d_b = '0; d_cin = 1'b0; d_ordy = 1'b1;

    r = model(2'd0, 200, 100, 0, 0, 0);
    chk("pin add sum", r.sum, 44); chk("pin add cout", r.cout, 1); chk("pin add ovf", r.ovf, 0);
    r = model(2'd0, 200, 100, 0, 0, 1);   chk("pin sat add sum", r.sum, 255);
    r = model(2'd1, 5, 7, 0, 0, 1);       chk("pin sat sub sum", r.sum, 0);
    r = model(2'd1, 5, 7, 0, 0, 0);
    chk("pin sub sum", r.sum, 254); chk("pin sub cout", r.cout, 0); chk("pin sub ovf", r.ovf, 0);
    r = model(2'd0, 127, 1, 0, 0, 0);     chk("pin add ovf sum", r.sum, 128); chk("pin add ovf", r.ovf, 1);
    r = model(2'd2, 250, 0, 0, 30, 0);    chk("pin acc sum", r.sum, 24); chk("pin acc cout", r.cout, 1);

    repeat (2) @(posedge clk); #1;
    chk("rst in_ready", bus0.in_ready, 0); chk("rst out_valid", bus0.out_valid, 0);
    chk("rst acc", bus0.acc, 0);           chk("rst sum", bus1.sum, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after reset", bus0.in_ready, 1);

    // Single ADD: latency and literal results on both instances.
    send(2'd0, 200, 100, 0);
    d_vld = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("lat out_valid k+1", bus0.out_valid, 0);
    @(negedge clk);
    chk("lat out_valid k+2", bus0.out_valid, 1);
    chk("lat sum nosat", bus0.sum, 44); chk("lat sum sat", bus1.sum, 255);
    chk("lat cout", bus0.cout, 1);      chk("lat ovf", bus0.ovf, 0);
    idle_cycles(2);

    send(2'd1, 5, 7, 0);
    send(2'd0, 127, 1, 0);
    send(2'd0, 255, 255, 1);
    send(2'd1, 128, 1, 0);
    send(2'd1, 0, 0, 0);
    idle_cycles(5);

    // Accumulator chain; the compare process checks in_ready stays low while each is in flight.
    send(2'd3, 10, 0, 0);
    d_vld = 1'b0;
    @(negedge clk);
    chk("hazard after LOAD", bus0.in_ready, 0);
    @(posedge clk); #1;
    send(2'd2, 20, 0, 0);
    send(2'd2, 250, 0, 0);
    idle_cycles(6);
    chk("acc chain nosat", bus0.acc, 24);
    chk("acc chain sat", bus1.acc, 255);

    // Back-to-back ADDs with a three-cycle downstream stall in the middle.
    n_before = n_out[0];
    fork
      begin
        for (int i = 1; i <= 6; i++) send(2'd0, i, 1, 0);
        d_vld = 1'b0;
      end
      begin
        repeat (3) @(posedge clk); #1 d_ordy = 1'b0;
        repeat (3) @(posedge clk); #1 d_ordy = 1'b1;
      end
    join
    idle_cycles(8);
    chk("stall beats delivered", n_out[0] - n_before, 6);
    chk("acc untouched by ADD", bus0.acc, 24);

    // Reset with two beats in flight.
    send(2'd0, 3, 4, 0);
    send(2'd0, 5, 6, 0);
    d_vld = 1'b0;
    n_before = n_out[0];
    #3 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", bus0.out_valid, 0);
    chk("mid rst acc", bus0.acc, 0);
    chk("mid rst acc sat", bus1.acc, 0);
    chk("mid rst in_ready", bus0.in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycles(8);
    chk("no stale output", n_out[0] - n_before, 0);

    send(2'd0, 1, 2, 0);
    idle_cycles(5);
    chk("queue0 drained", q0.size(), 0);
    chk("queue1 drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
